// File: rtl/spi_rx_pkg.sv
// spi_rx_pkg: shared frame layout, FSM states and helpers for spi_setpoint_rx.
package spi_rx_pkg;
    localparam int HDR_W   = 8;
    localparam int REL_BIT = 7;
    localparam int RSV_BIT = 6;
    localparam int CH_MSB  = 5;
    localparam logic [7:0] DEF_MARKER = 8'hA5;

    typedef enum logic [1:0] {IDLE, ACTIVE, COMMIT} state_t;

    function automatic logic [7:0] sat_inc8(input logic [7:0] v);
        return (v == 8'hFF) ? v : v + 8'd1;
    endfunction
endpackage

// File: rtl/spi_setpoint_rx_sync_edge.sv
// sync_edge: multi-flop synchroniser with one-clk rise/fall pulses on the synchronised value.
module sync_edge #(
    parameter int   SYNC_STAGES = 2,
    parameter logic RST_VAL     = 1'b0
) (
    input  logic clk,
    input  logic rst,
    input  logic async,
    output logic sync,
    output logic rise,
    output logic fall
);
    logic [SYNC_STAGES-1:0] q;
    logic                   prev;

    // Reset to the line's idle level so releasing reset does not fake an edge.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q    <= {SYNC_STAGES{RST_VAL}};
            prev <= RST_VAL;
        end else begin
            q    <= {q[SYNC_STAGES-2:0], async};
            prev <= q[SYNC_STAGES-1];
        end
    end

    assign sync = q[SYNC_STAGES-1];
    assign rise = sync & ~prev;
    assign fall = ~sync & prev;
endmodule

// File: rtl/spi_setpoint_rx.sv
// spi_setpoint_rx: oversampled SPI mode-0 slave writing absolute/relative setpoints
// into NUM_CH channel registers and returning a position snapshot on sdo.
module spi_setpoint_rx
    import spi_rx_pkg::*;
#(
    parameter int         DATA_W      = 16,
    parameter int         NUM_CH      = 4,
    parameter int         SYNC_STAGES = 2,
    parameter logic [7:0] MARKER      = DEF_MARKER
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     sck,
    input  logic                     sdi,
    output logic                     sdo,
    input  logic                     nss,
    input  logic signed [DATA_W-1:0] position,
    output logic [NUM_CH*DATA_W-1:0] ch_val,
    output logic                     upd,
    output logic [5:0]               upd_ch,
    output logic                     frame_err,
    output logic [7:0]               err_cnt,
    output logic                     busy
);
    localparam int FRAME_W = HDR_W + DATA_W;
    localparam int CNT_W   = $clog2(FRAME_W + 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(FRAME_W);
    localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(FRAME_W + 1);

    logic                   sck_s, sck_rise, sck_fall;
    logic                   nss_s, nss_rise, nss_fall;
    logic [SYNC_STAGES-1:0] sdi_q;
    logic                   sdi_s;
    state_t                 state;
    logic [FRAME_W-1:0]     sr, tx;
    logic [CNT_W-1:0]       cnt;
    logic [DATA_W-1:0]      snap;
    logic [DATA_W-1:0]      regs [NUM_CH];
    logic [HDR_W-1:0]       hdr;
    logic [DATA_W-1:0]      data;
    logic [5:0]             ch;
    logic                   ok;

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sck (
        .clk(clk), .rst(rst), .async(sck), .sync(sck_s), .rise(sck_rise), .fall(sck_fall)
    );

    sync_edge #(.SYNC_STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_nss (
        .clk(clk), .rst(rst), .async(nss), .sync(nss_s), .rise(nss_rise), .fall(nss_fall)
    );

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) sdi_q <= '0;
        else      sdi_q <= {sdi_q[SYNC_STAGES-2:0], sdi};
    end

    assign sdi_s = sdi_q[SYNC_STAGES-1];
    assign hdr   = sr[FRAME_W-1 -: HDR_W];
    assign data  = sr[DATA_W-1:0];
    assign ch    = hdr[CH_MSB:0];
    assign ok    = (cnt == CNT_FULL) && (int'(ch) < NUM_CH) && !hdr[RSV_BIT];

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            sr        <= '0;
            tx        <= '0;
            cnt       <= '0;
            snap      <= '0;
            sdo       <= 1'b0;
            busy      <= 1'b0;
            upd       <= 1'b0;
            upd_ch    <= '0;
            frame_err <= 1'b0;
            err_cnt   <= '0;
            for (int k = 0; k < NUM_CH; k++) regs[k] <= '0;
        end else begin
            upd       <= 1'b0;
            frame_err <= 1'b0;
            case (state)
                IDLE: begin
                    if (nss_fall) begin
                        state <= ACTIVE;
                        snap  <= position;
                        cnt   <= '0;
                        busy  <= 1'b1;
                        sdo   <= MARKER[7];
                        tx    <= {MARKER[6:0], position, 1'b0};
                    end
                end
                ACTIVE: begin
                    if (sck_rise) begin
                        sr  <= {sr[FRAME_W-2:0], sdi_s};
                        cnt <= (cnt == CNT_MAX) ? cnt : cnt + 1'b1;
                    end
                    if (sck_fall) begin
                        sdo <= tx[FRAME_W-1];
                        tx  <= tx << 1;
                    end
                    // A coincident sck_rise is absorbed above before COMMIT looks at the count.
                    if (nss_rise) begin
                        state <= COMMIT;
                        sdo   <= 1'b0;
                    end
                end
                COMMIT: begin
                    state     <= IDLE;
                    busy      <= 1'b0;
                    upd       <= ok;
                    frame_err <= !ok;
                    if (ok) upd_ch  <= ch;
                    else    err_cnt <= sat_inc8(err_cnt);
                    for (int k = 0; k < NUM_CH; k++)
                        if (ok && int'(ch) == k) regs[k] <= hdr[REL_BIT] ? snap - data : data;
                end
                default: state <= IDLE;
            endcase
        end
    end

    for (genvar g = 0; g < NUM_CH; g++) begin : g_out
        assign ch_val[g*DATA_W +: DATA_W] = regs[g];
    end

    logic unused;
    assign unused = sck_s ^ nss_s;
endmodule

// File: tb/tb_spi_setpoint_rx.sv
// tb_spi_setpoint_rx: randomized SPI host driving spi_setpoint_rx against a frame-level model.
`timescale 1ns/1ps
module tb_spi_setpoint_rx;
    localparam int DW  = 16;
    localparam int NCH = 4;
    localparam int SS  = 2;
    localparam int H   = 8;

    logic                 clk = 1'b0;
    logic                 rst = 1'b0;
    logic                 sck = 1'b0;
    logic                 sdi = 1'b0;
    logic                 nss = 1'b1;
    logic                 sdo;
    logic signed [DW-1:0] position = '0;
    logic [NCH*DW-1:0]    ch_val;
    logic                 upd;
    logic [5:0]           upd_ch;
    logic                 frame_err;
    logic [7:0]           err_cnt;
    logic                 busy;

    int          tests = 0;
    int          fails = 0;
    int          upd_total = 0;
    logic [DW-1:0] m_ch [NCH];
    int          m_err = 0;

    spi_setpoint_rx #(.DATA_W(DW), .NUM_CH(NCH), .SYNC_STAGES(SS), .MARKER(8'hA5)) dut (
        .clk(clk), .rst(rst), .sck(sck), .sdi(sdi), .sdo(sdo), .nss(nss),
        .position(position), .ch_val(ch_val), .upd(upd), .upd_ch(upd_ch),
        .frame_err(frame_err), .err_cnt(err_cnt), .busy(busy)
    );

    always #5 clk = ~clk;

    always @(negedge clk) if (upd) upd_total++;

    initial begin
        #5_000_000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        tests++;
        if (got !== exp) begin
            fails++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    task automatic check_all(input string tag);
        for (int k = 0; k < NCH; k++)
            check($sformatf("%s ch%0d", tag, k), ch_val[k*DW +: DW], m_ch[k]);
        check({tag, " err_cnt"}, err_cnt, m_err);
    endtask

    task automatic model_reset();
        for (int k = 0; k < NCH; k++) m_ch[k] = '0;
        m_err = 0;
    endtask

    // Sends n bits of word (MSB first), records the sdo bits the host sees, then checks the outcome.
    task automatic frame(input logic [31:0] word, input int n, input logic [DW-1:0] pos, input bit mid);
        logic [23:0]       exp_tx;
        logic [31:0]       rx;
        logic [7:0]        hdr;
        logic [NCH*DW-1:0] cv;
        bit                ok;
        int                code, lat, idx;
        exp_tx = {8'hA5, pos};
        rx     = '0;
        cv     = '0;
        hdr    = word[23:16];
        idx    = int'(hdr[5:0]);
        ok     = (n == 24) && (idx < NCH) && !hdr[6];
        @(negedge clk);
        position = pos;
        nss      = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < n; i++) begin
            sdi = word[n-1-i];
            if (mid && i == 8) position = $urandom;
            repeat (H) @(negedge clk);
            if (i < 24) rx = {rx[30:0], sdo};
            sck = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
        repeat (H) @(negedge clk);
        check("busy_active", busy, 1);
        nss  = 1'b1;
        code = 0;
        lat  = 0;
        for (int i = 1; i <= 20 && code == 0; i++) begin
            @(negedge clk);
            if (upd) begin
                code = 1;
                lat  = i;
                cv   = ch_val;
            end else if (frame_err) code = 2;
        end
        if (ok) m_ch[idx] = hdr[7] ? pos - word[15:0] : word[15:0];
        else if (m_err < 255) m_err++;
        check("outcome", code, ok ? 1 : 2);
        if (ok) begin
            check("latency", lat, SS + 2);
            check("upd_ch", upd_ch, hdr[5:0]);
            check("ch_at_upd", cv[idx*DW +: DW], m_ch[idx]);
        end
        if (n > 0) check("sdo", rx, (n >= 24) ? exp_tx : (exp_tx >> (24 - n)));
        @(negedge clk);
        check("pulse_width", {upd, frame_err}, 2'b00);
        check("sdo_idle", sdo, 0);
        check("busy_idle", busy, 0);
        check_all("frame");
        repeat (3) @(negedge clk);
    endtask

    initial begin
        logic [7:0]  hdr;
        logic [15:0] d;
        int          n, base;
        model_reset();
        repeat (3) @(negedge clk);
        check_all("in_reset");
        check("rst_sdo", sdo, 0);
        check("rst_busy", busy, 0);
        check("rst_upd_ch", upd_ch, 0);
        rst = 1'b1;
        repeat (5) @(negedge clk);
        check("idle_flags", {upd, frame_err, busy}, 3'b000);

        frame({8'h02, 16'h1234}, 24, 16'h0000, 0);
        frame({8'h80, 16'd30}, 24, 16'd100, 0);
        frame({8'h80, 16'd30}, 24, 16'd10, 0);
        check("rel_wrap", ch_val[15:0], 16'hFFEC);
        frame({8'h03, 16'($urandom)}, 24, 16'hBEEF, 1);

        frame(32'($urandom) & 32'h007F_FFFF, 23, 16'($urandom), 0);
        frame({8'h07, 16'($urandom)}, 24, 16'($urandom), 0);
        frame({8'h41, 16'($urandom)}, 24, 16'($urandom), 0);
        frame(32'($urandom) & 32'h01FF_FFFF, 25, 16'($urandom), 0);
        check("bad_cnt", err_cnt, 4);

        for (int t = 0; t < 14; t++) begin
            hdr = {1'($urandom), 1'b0, 6'($urandom_range(0, NCH - 1))};
            if ($urandom_range(0, 4) == 0) hdr[6] = 1'b1;
            if ($urandom_range(0, 4) == 0) hdr[5:0] = 6'($urandom_range(NCH, 63));
            n = ($urandom_range(0, 5) == 0) ? 23 + 2 * $urandom_range(0, 1) : 24;
            d = 16'($urandom);
            frame({8'h00, hdr, d} >> (24 - n), n, 16'($urandom), 1'($urandom));
        end

        @(negedge clk);
        nss = 1'b0;
        repeat (H) @(negedge clk);
        for (int i = 0; i < 10; i++) begin
            sdi = 1'($urandom);
            repeat (H) @(negedge clk);
            sck = 1'b1;
            repeat (H) @(negedge clk);
            sck = 1'b0;
        end
        rst = 1'b0;
        repeat (2) @(negedge clk);
        nss = 1'b1;
        repeat (3) @(negedge clk);
        model_reset();
        check_all("mid_reset");
        rst = 1'b1;
        repeat (6) @(negedge clk);
        check("post_reset_flags", {frame_err, busy, sdo}, 3'b000);
        frame({8'h01, 16'h0005}, 24, 16'($urandom), 0);
        check("reset_ch1", ch_val[31:16], 16'd5);

        for (int t = 0; t < 300; t++)
            frame(32'($urandom), $urandom_range(1, 5), 16'($urandom), 0);
        check("sat_cnt", err_cnt, 255);

        base = upd_total;
        frame({8'h03, 16'd7}, 24, 16'($urandom), 0);
        frame({8'h03, 16'd9}, 24, 16'($urandom), 0);
        check("b2b_upd", upd_total - base, 2);
        check("b2b_ch3", ch_val[63:48], 16'd9);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/spi_setpoint_rx.md
Name: spi_setpoint_rx

Overview:
- Multi-channel SPI slave for MCU-to-FPGA control updates (setpoints, gains, limits). Parametrised successor to the single-register two-byte receiver.
- Oversamples sck/sdi/nss in the system clock domain, so there is no sck-domain logic.
- Decodes a header plus a data word per frame, commits it to one of NUM_CH registers (absolute or position-relative), and streams a position snapshot back on sdo.
- Sits between the SPI pins and pid_16 / the top-level gain assigns.

Parameters:
- DATA_W, 16, width of each channel register and data field.
- NUM_CH, 4, number of channel registers (1..64).
- SYNC_STAGES, 2, synchroniser depth for sck, sdi, nss (>=2).
- MARKER, 8'hA5, byte returned on sdo during the header phase.

Ports:
- clk, input, 1, system clock (HSOSC). Must be >= 4x the sck frequency.
- rst, input, 1, asynchronous, active-low reset (asserted at 0).
- sck, input, 1, SPI clock, mode 0, idle low.
- sdi, input, 1, MOSI, MSB first.
- sdo, output, 1, MISO, MSB first.
- nss, input, 1, chip select, active low.
- position, input, DATA_W signed, live encoder position.
- ch_val, output, NUM_CH*DATA_W, channel registers; channel k is bits [k*DATA_W +: DATA_W].
- upd, output, 1, one-clk pulse when a frame commits.
- upd_ch, output, 6, channel index of the last commit.
- frame_err, output, 1, one-clk pulse when a frame is rejected.
- err_cnt, output, 8, rejected-frame count; saturates at 255.
- busy, output, 1, high while a frame is in progress.

Behaviour:
- Reset (rst=0, async) clears: ch_val, upd, upd_ch, frame_err, err_cnt, busy, sdo, bit counter, shift register, snapshot. State returns to IDLE. A frame in progress is discarded, and no error is counted for it.
- Synchronisation: sck, sdi and nss each pass through SYNC_STAGES flops.
- Edge detect on the synchronised signals gives sck_rise, sck_fall, nss_fall and nss_rise, each one clk wide.
- Frame format: 8-bit header, then DATA_W data bits.
  - hdr[7] = REL.
  - hdr[6] reserved; it must be 0.
  - hdr[5:0] = channel index.
- States:
  - IDLE -> ACTIVE on nss_fall. Latch snap <= position, clear the bit counter, set busy=1, load the sdo shifter with {MARKER, snap}.
  - ACTIVE:
    - On sck_rise: shift the synchronised sdi into the LSB and increment the counter (saturating at 8+DATA_W+1).
    - On sck_fall: advance the sdo shifter. The first bit (MARKER[7]) is driven on sdo from entry to ACTIVE.
    - On nss_rise: go to COMMIT.
  - COMMIT (one clk) -> IDLE. busy=0.
- Commit rule: commit only if all three hold:
  - counter == 8+DATA_W exactly;
  - channel index < NUM_CH;
  - hdr[6] == 0.
- On commit:
  - ch_val[ch] <= REL ? (snap - data) : data. Arithmetic is mod 2^DATA_W and wraps with no saturation.
  - upd=1 for one clk; upd_ch <= ch.
- Otherwise (short frame, long frame, bad channel, reserved bit set): frame_err=1 for one clk and err_cnt++ (saturating at 255). ch_val and upd_ch are unchanged.
- Latency: upd is asserted SYNC_STAGES+2 clks after the nss pin rises. ch_val is valid in the same cycle as upd.
- Edge collisions:
  - nss_rise in the same clk as sck_rise: the bit is shifted and counted first, then COMMIT evaluates.
  - nss_fall while in COMMIT: it is ignored, and the frame is missed (the host must hold nss high >= 4 clks).
- sdo is 0 when not ACTIVE. It is not tri-stated; the team shares no bus on this SPI.
- Header bits are taken from shift-register bits [8+DATA_W-1 : DATA_W] at commit, not during the frame.

Decomposition:
- Package spi_rx_pkg holds:
  - HDR_W=8, REL_BIT=7, RSV_BIT=6, CH_MSB=5;
  - the state enum {IDLE, ACTIVE, COMMIT};
  - the default MARKER.
- Sub-module sync_edge: parameter SYNC_STAGES; ports clk, rst, async in, sync out, rise, fall. Instantiate it once each for sck and nss; sdi uses its sync output only.

Test Plan:
- Absolute write: frame hdr=8'h02, data=16'h1234 -> ch_val[2]=16'h1234; upd pulse with upd_ch=2; other channels stay 0; frame_err stays 0.
- Relative write: position=16'd100 at nss fall, hdr=8'h80, data=16'd30 -> ch_val[0]=16'd70. Then repeat with position=16'd10, data=16'd30 -> ch_val[0]=16'hFFEC (wrap to -20).
- sdo readback: position=16'hBEEF -> host captures 8'hA5 followed by 16'hBEEF over 24 sck edges. A position change mid-frame does not alter the shifted bits.
- Bad frames:
  - 23-bit frame -> frame_err pulse, err_cnt=1;
  - hdr=8'h07 with NUM_CH=4 -> err_cnt=2;
  - hdr=8'h41 -> err_cnt=3;
  - 25-bit frame -> err_cnt=4;
  - ch_val is unchanged throughout.
- Reset mid-frame: pull rst low after 10 bits, release, then send a valid frame hdr=8'h01, data=16'h0005 -> no error counted, ch_val[1]=5.
- Saturation and back-to-back:
  - 300 short frames -> err_cnt=255;
  - then two valid frames to ch 3 with values 7 and 9, separated by 4 clks of nss high -> two upd pulses; final ch_val[3]=9.
